// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and constants for the multi-cycle control sequencer
//
// Purpose: state encoding, supported opcodes, ALU operation codes and the
//          opcode classification helpers used by multicycle_control.
// Ports:   none (package).
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MWB    = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDIU) || (op == OP_ORI) ||
               (op == OP_LW)    || (op == OP_SW);
    endfunction

    // ALU controls shared by EXEC and WB (WB holds what EXEC drove).
    function automatic logic [1:0] exec_alu_op(input logic [5:0] op);
        if (op == OP_RTYPE)
            return ALUOP_FUNCT;
        else if (op == OP_ORI)
            return ALUOP_OR;
        else
            return ALUOP_ADD;
    endfunction

    function automatic logic exec_alu_src(input logic [5:0] op);
        return (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - wrap-around retired-instruction counter
//
// Purpose: COUNT_W-bit counter, increments by one when i_inc is high,
//          wraps from all-ones to zero.
// Ports:   i_clk   - clock
//          i_rst   - asynchronous active-high reset (clears count)
//          i_inc   - increment enable
//          o_count - current count
module retire_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_inc,
    output logic [COUNT_W-1:0] o_count
);

    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_inc)
            r_count <= r_count + COUNT_W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle Moore control sequencer for the I-format datapath
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB/MWB,
//          drives datapath enables, waits on data-memory ready, flags
//          unsupported opcodes and counts retired instructions.
// Ports:   i_clk, i_rst          - clock, asynchronous active-high reset
//          i_run                 - allow FETCH to issue a new instruction
//          i_opcode[5:0]         - Instr[31:26], used only in DECODE
//          i_mem_ready           - data memory access complete (MEM only)
//          o_pc_write/o_ir_write - PC and IR load enables
//          o_reg_write/o_reg_dst/o_mem_to_reg - register file controls
//          o_alu_src/o_alu_op    - ALU operand select and operation
//          o_mem_read/o_mem_write - data memory strobes
//          o_illegal             - sticky unsupported-opcode flag
//          o_state[2:0]          - current state, for debug
//          o_retired             - retired instruction count
module multicycle_control
    import mc_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic [5:0]         i_opcode,
    input  logic               i_mem_ready,
    output logic               o_pc_write,
    output logic               o_ir_write,
    output logic               o_reg_write,
    output logic               o_reg_dst,
    output logic               o_alu_src,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic [1:0]         o_alu_op,
    output logic               o_illegal,
    output logic [2:0]         o_state,
    output logic [COUNT_W-1:0] o_retired
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic       r_illegal;
    logic       w_retire;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_FETCH;
        else
            r_state <= w_next;
    end

    // Opcode latch and sticky illegal flag, both captured in DECODE only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_op <= i_opcode;
            if (!is_supported(i_opcode))
                r_illegal <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = i_run ? ST_DECODE : ST_FETCH;
            ST_DECODE: w_next = is_supported(i_opcode) ? ST_EXEC : ST_FETCH;
            ST_EXEC:   w_next = ((r_op == OP_LW) || (r_op == OP_SW)) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (i_mem_ready)
                    w_next = (r_op == OP_LW) ? ST_MWB : ST_FETCH;
            end
            ST_WB:     w_next = ST_FETCH;
            ST_MWB:    w_next = ST_FETCH;
            default:   w_next = ST_FETCH;
        endcase
    end

    // An instruction retires on the transition that ends it: WB, MWB, or a
    // completed store in MEM. An illegal opcode leaves DECODE without retiring.
    assign w_retire = (r_state == ST_WB) || (r_state == ST_MWB) ||
                      ((r_state == ST_MEM) && i_mem_ready && (r_op == OP_SW));

    // Output decode from state and latched opcode only.
    always_comb begin
        o_pc_write   = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_op     = ALUOP_ADD;
        case (r_state)
            ST_FETCH: begin
                o_pc_write = i_run;
                o_ir_write = i_run;
            end
            ST_EXEC: begin
                o_alu_src = exec_alu_src(r_op);
                o_alu_op  = exec_alu_op(r_op);
            end
            ST_MEM: begin
                o_alu_src   = 1'b1;
                o_alu_op    = ALUOP_ADD;
                o_mem_read  = (r_op == OP_LW);
                o_mem_write = (r_op == OP_SW);
            end
            ST_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = (r_op == OP_RTYPE);
                o_alu_src   = exec_alu_src(r_op);
                o_alu_op    = exec_alu_op(r_op);
            end
            ST_MWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            default: begin
                o_pc_write = 1'b0;
            end
        endcase
    end

    assign o_illegal = r_illegal;
    assign o_state   = r_state;

    retire_counter #(
        .COUNT_W (COUNT_W)
    ) u_retire_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_retire),
        .o_count (o_retired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard testbench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        pc_write, ir_write, reg_write, reg_dst, alu_src;
    logic        mem_read, mem_write, mem_to_reg, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        s_pc_write, s_ir_write, s_reg_write, s_reg_dst, s_alu_src;
    logic        s_mem_read, s_mem_write, s_mem_to_reg, s_illegal;
    logic [1:0]  s_alu_op;
    logic [2:0]  s_state;
    logic [2:0]  retired3;

    always #5 clk = ~clk;

    multicycle_control #(.COUNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_reg_write(reg_write),
        .o_reg_dst(reg_dst), .o_alu_src(alu_src), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg), .o_alu_op(alu_op),
        .o_illegal(illegal), .o_state(state), .o_retired(retired)
    );

    multicycle_control #(.COUNT_W(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .o_pc_write(s_pc_write), .o_ir_write(s_ir_write), .o_reg_write(s_reg_write),
        .o_reg_dst(s_reg_dst), .o_alu_src(s_alu_src), .o_mem_read(s_mem_read),
        .o_mem_write(s_mem_write), .o_mem_to_reg(s_mem_to_reg), .o_alu_op(s_alu_op),
        .o_illegal(s_illegal), .o_state(s_state), .o_retired(retired3)
    );

    typedef struct {
        int     cycles;
        longint sig;
        int     n_pcw, n_irw, n_regw, n_mrd, n_mwr;
        int     ex_aluop, ex_alusrc;
        int     wb_regdst, wb_mtr, wb_aluop, wb_alusrc;
        int     ret;
        int     ill;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_ret = 0;
    int   model_ill = 0;
    bit   mon_en = 1'b0;
    bit   in_instr = 1'b0;
    rec_t obs;

    task automatic chk(input string nm, input longint act, input longint exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: per-instruction expectations from the opcode rules.
    task automatic push_exp(input logic [5:0] op, input int w);
        rec_t e;
        bit legal, is_r, is_ai, is_ori, is_lw, is_sw;
        int seq[$];
        e = '{default: 0};
        is_r   = (op == 6'h00);
        is_ai  = (op == 6'h09);
        is_ori = (op == 6'h0D);
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        legal  = is_r | is_ai | is_ori | is_lw | is_sw;
        seq = '{0, 1};
        if (legal) seq.push_back(2);
        if (is_lw || is_sw) for (int k = 0; k <= w; k++) seq.push_back(3);
        if (is_lw) seq.push_back(5);
        if (is_r || is_ai || is_ori) seq.push_back(4);
        foreach (seq[k]) e.sig = (e.sig << 3) | longint'(seq[k]);
        e.cycles = seq.size();
        e.n_pcw = 1;
        e.n_irw = 1;
        if (legal) begin
            e.ex_aluop  = is_r ? 2 : (is_ori ? 3 : 0);
            e.ex_alusrc = is_r ? 0 : 1;
        end
        if (is_r || is_ai || is_ori) begin
            e.n_regw    = 1;
            e.wb_regdst = is_r ? 1 : 0;
            e.wb_aluop  = e.ex_aluop;
            e.wb_alusrc = e.ex_alusrc;
        end
        if (is_lw) begin
            e.n_regw = 1;
            e.wb_mtr = 1;
            e.n_mrd  = w + 1;
        end
        if (is_sw) e.n_mwr = w + 1;
        if (legal) model_ret++;
        else model_ill = 1;
        e.ret = model_ret;
        e.ill = model_ill;
        exp_q.push_back(e);
    endtask

    // Monitor: an instruction spans a FETCH cycle with pc_write high up to
    // the next return to FETCH; its observed footprint is compared on return.
    always @(negedge clk) begin
        if (!mon_en) begin
            in_instr = 1'b0;
        end else begin
            if (in_instr && state == 3'd0) begin
                in_instr = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr", 1, 0);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    chk("cycles", obs.cycles, e.cycles);
                    chk("state_trace", obs.sig, e.sig);
                    chk("pc_write_cycles", obs.n_pcw, e.n_pcw);
                    chk("ir_write_cycles", obs.n_irw, e.n_irw);
                    chk("reg_write_cycles", obs.n_regw, e.n_regw);
                    chk("mem_read_cycles", obs.n_mrd, e.n_mrd);
                    chk("mem_write_cycles", obs.n_mwr, e.n_mwr);
                    chk("exec_alu_op", obs.ex_aluop, e.ex_aluop);
                    chk("exec_alu_src", obs.ex_alusrc, e.ex_alusrc);
                    chk("wb_reg_dst", obs.wb_regdst, e.wb_regdst);
                    chk("wb_mem_to_reg", obs.wb_mtr, e.wb_mtr);
                    chk("wb_alu_op", obs.wb_aluop, e.wb_aluop);
                    chk("wb_alu_src", obs.wb_alusrc, e.wb_alusrc);
                    chk("retired", longint'(retired), longint'(e.ret));
                    chk("retired_w3", longint'(retired3), longint'(e.ret & 7));
                    chk("illegal", longint'(illegal), longint'(e.ill));
                end
            end
            if (!in_instr && state == 3'd0 && pc_write) begin
                in_instr = 1'b1;
                obs = '{default: 0};
            end
            if (in_instr) begin
                obs.cycles++;
                obs.sig = (obs.sig << 3) | longint'(state);
                obs.n_pcw  += int'(pc_write);
                obs.n_irw  += int'(ir_write);
                obs.n_regw += int'(reg_write);
                obs.n_mrd  += int'(mem_read);
                obs.n_mwr  += int'(mem_write);
                if (state == 3'd2) begin
                    obs.ex_aluop  = int'(alu_op);
                    obs.ex_alusrc = int'(alu_src);
                end
                if (reg_write) begin
                    obs.wb_regdst = int'(reg_dst);
                    obs.wb_mtr    = int'(mem_to_reg);
                    obs.wb_aluop  = int'(alu_op);
                    obs.wb_alusrc = int'(alu_src);
                end
            end
        end
    end

    // Issue one instruction; mem_ready stays low for w MEM cycles.
    task automatic issue(input logic [5:0] op, input int w);
        @(posedge clk); #1;
        opcode = op; run = 1'b1; mem_ready = 1'b0;
        push_exp(op, w);
        @(posedge clk); #1;                 // DECODE
        run = 1'b0;
        mem_ready = 1'($urandom);           // ignored outside MEM
        @(posedge clk); #1;                 // EXEC
        mem_ready = (w == 0);
        @(posedge clk); #1;                 // first MEM cycle (if any)
        repeat (w) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        repeat (3 + $urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        logic [5:0] ops [5];
        ops = '{6'h00, 6'h09, 6'h0D, 6'h23, 6'h2B};

        rst = 1'b1; run = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
        #12;
        chk("reset_state", longint'(state), 0);
        chk("reset_retired", longint'(retired), 0);
        chk("reset_illegal", longint'(illegal), 0);
        chk("reset_pc_write_run0", longint'(pc_write), 0);
        run = 1'b1;
        #1;
        chk("reset_pc_write_run1", longint'(pc_write), 1);
        chk("reset_ir_write_run1", longint'(ir_write), 1);
        run = 1'b0;
        #2 rst = 1'b0;
        mon_en = 1'b1;

        // Nine addiu: the 3-bit counter passes 7, wraps to 0, ends at 1.
        for (int i = 0; i < 9; i++) issue(6'h09, 0);
        chk("wrap_retired_w3", longint'(retired3), 1);
        chk("wrap_retired", longint'(retired), 9);

        issue(6'h00, 0);            // R-type
        issue(6'h23, 2);            // lw with two wait cycles
        issue(6'h2B, 0);            // sw, ready on entry
        issue(6'h3F, 0);            // illegal
        issue(6'h0D, 0);            // ori after illegal

        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [5:0] op;
            sel = $urandom_range(0, 6);
            if (sel < 5) op = ops[sel];
            else if (sel == 5) op = 6'h3F;
            else op = 6'($urandom);
            issue(op, $urandom_range(0, 3));
        end
        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);

        // Reset during a stalled store.
        mon_en = 1'b0;
        @(posedge clk); #1;
        opcode = 6'h2B; run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1; run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_mem_state", longint'(state), 3);
        chk("mid_mem_write", longint'(mem_write), 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_mem_write", longint'(mem_write), 0);
        chk("rst_state", longint'(state), 0);
        chk("rst_retired", longint'(retired), 0);
        chk("rst_retired_w3", longint'(retired3), 0);
        chk("rst_illegal", longint'(illegal), 0);
        #3 rst = 1'b0;
        model_ret = 0; model_ill = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_state", longint'(state), 0);
        chk("idle_pc_write", longint'(pc_write), 0);

        mon_en = 1'b1;
        issue(6'h09, 0);
        issue(6'h23, 0);
        repeat (4) @(posedge clk);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the I-format CPU datapath: replaces the single-cycle combinational control decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the existing register file, ALU control, data memory and PC/IR write enables. It also waits on a data-memory ready handshake, flags unsupported opcodes and counts retired instructions.

## Interface
- `COUNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `run` input 1: high lets FETCH issue a new instruction; low holds in FETCH.
- `opcode` input 6: `Instr[31:26]` from the instruction register.
- `mem_ready` input 1: data memory completed the current access (sampled in MEM).
- `pc_write` output 1: load PC with adder output.
- `ir_write` output 1: load instruction register from IM.
- `reg_write` output 1: RF write enable.
- `reg_dst` output 1: 1 selects `Instr[15:11]`, 0 selects `Instr[20:16]`.
- `alu_src` output 1: 1 selects the zero-extended immediate.
- `mem_read`, `mem_write` output 1 each: DM strobes.
- `mem_to_reg` output 1: 1 selects DM read data for RF write-back.
- `alu_op` output 2: 00 add, 01 sub (reserved), 10 use funct, 11 or.
- `illegal` output 1: sticky; an unsupported opcode was decoded.
- `state` output 3: current state encoding, for debug.
- `retired` output COUNT_W: count of completed instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MWB=5. Codes 6 and 7 go to FETCH.
- Supported opcodes: R-type 6'h00, addiu 6'h09, ori 6'h0D, lw 6'h23, sw 6'h2B.
- FETCH: `pc_write` and `ir_write` equal `run`. Go to DECODE when `run`=1, otherwise stay.
- DECODE: latch `opcode` into `op_q`. A supported opcode goes to EXEC. An unsupported one sets `illegal`, goes to FETCH and performs no RF or DM write.
- EXEC: `alu_src`=1 for addiu/ori/lw/sw. `alu_op`=10 for R-type, 11 for ori, 00 otherwise. R-type/addiu/ori go to WB; lw/sw go to MEM.
- MEM: `alu_src`=1, `alu_op`=00. `mem_read` (lw) or `mem_write` (sw) is held every cycle until `mem_ready`=1 is sampled. Then lw goes to MWB and sw goes to FETCH (sw retires).
- WB: `reg_write`=1, `reg_dst`=1 for R-type only, `mem_to_reg`=0. The ALU controls of EXEC are held. Go to FETCH and retire.
- MWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Go to FETCH and retire.
- All outputs are decoded from `state` and `op_q` only (Moore); `opcode` is used only in DECODE.
- Any output not listed for a state is 0.
- `retired` increments by 1 on each retire transition and wraps to 0 after all-ones. An illegal opcode does not retire.

## Timing
- Reset (async, immediate): `state`=FETCH, `op_q`=0, `illegal`=0, `retired`=0, all strobes 0. `pc_write`/`ir_write` then follow `run`.
- Reset during MEM drops `mem_write`/`mem_read` the same instant. The partial instruction does not retire.
- Latency with `mem_ready` already high: R-type/addiu/ori take 4 cycles, sw 4, lw 5. Each cycle of `mem_ready`=0 in MEM adds 1.
- `mem_ready` is ignored outside MEM. A `mem_ready` high on MEM entry completes the access in one cycle.
- `run` is sampled only in FETCH. Deasserting it mid-instruction lets the current instruction finish, then the block idles in FETCH.
- `illegal` stays set until reset.

## Structure
- Package `mc_pkg`: state enum (3-bit), opcode constants, `alu_op` constants (ALUOP_ADD/SUB/FUNCT/OR).
- Sub-module `retire_counter`: COUNT_W-bit wrap-around counter with async reset and increment enable.
- Top block: state register, `op_q`, `illegal` flag, next-state logic and output decode.

## Test plan
- Reset then `run`=1 with `opcode`=00 → states 0,1,2,4,0. `reg_write`=1 and `reg_dst`=1 only in WB with `alu_op`=10. `retired`=1 after 4 cycles.
- lw (6'h23) with `mem_ready` low for 2 MEM cycles → `mem_read` high for 3 cycles, then MWB with `mem_to_reg`=1. Total 7 cycles, `retired`=1.
- sw (6'h2B) with `mem_ready`=1 → `mem_write` high exactly 1 cycle, `reg_write` never high, back to FETCH after 4 cycles.
- `opcode`=6'h3F → `illegal`=1 after DECODE, FETCH next, no RF/DM strobe, `retired` unchanged. A following ori (6'h0D) executes normally with `alu_op`=11.
- Assert `rst` mid-MEM of sw with `mem_ready`=0 → `mem_write`=0 immediately, `state`=0, `retired`=0. `run`=0 afterwards holds FETCH with `pc_write`=0.
- `COUNT_W`=3, 9 addiu instructions → `retired` reaches 7, wraps to 0, ends at 1.
